// File: rtl/uart_tx_scheduler.sv
// Purpose: round-robin share of one UART transmitter among NUM_REQ word sources; each granted word goes out LSB byte first.
// Latency: request in IDLE -> o_grant next cycle -> first o_tx_start the cycle after; i_tx_done -> next o_tx_start 2 cycles.
// Backpressure: requesters hold i_req until o_grant; bytes are paced only by i_tx_done, exactly one start per byte.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req / i_word          per-requester level request and word (requester k at [k*DATA_W +: DATA_W])
//   o_grant                 one-hot pulse: that requester's word was latched
//   o_busy                  high from grant until the final byte's done
//   o_tx_start / o_tx_data  to the UART: start pulse and byte (byte held until i_tx_done)
//   i_tx_done               from the UART: stop bit finished
//   o_word_done / o_done_id pulse after the last byte, with the index of the requester served
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int WORD_BYTES = 4,
  localparam int DATA_W    = 8 * WORD_BYTES,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CNT_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_word,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_tx_start,
  output logic [7:0]                o_tx_data,
  input  logic                      i_tx_done,
  output logic                      o_word_done,
  output logic [ID_W-1:0]           o_done_id
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shift_q, shift_nxt;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [ID_W-1:0]    last_grant, last_grant_nxt;
  logic [ID_W-1:0]    winner;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               busy_nxt, tx_start_nxt, word_done_nxt;
  logic [7:0]         tx_data_nxt;
  logic [ID_W-1:0]    done_id_nxt;
  logic [DATA_W-1:0]  words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = i_word[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: scan last_grant+1, +2, ... wrapping. Scanning from the
  // far end down means the nearest requesting index is assigned last and wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req[ID_W'(idx)]) winner = ID_W'(idx);
    end
  end

  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift_q;
    byte_cnt_nxt   = byte_cnt;
    last_grant_nxt = last_grant;
    grant_nxt      = '0;
    busy_nxt       = o_busy;
    tx_start_nxt   = 1'b0;
    tx_data_nxt    = o_tx_data;
    word_done_nxt  = 1'b0;
    done_id_nxt    = o_done_id;
    case (state)
      ST_IDLE: begin
        if (|i_req) begin
          shift_nxt      = words[winner];
          grant_nxt      = NUM_REQ'(1) << winner;
          last_grant_nxt = winner;
          byte_cnt_nxt   = '0;
          busy_nxt       = 1'b1;
          state_nxt      = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = shift_q[7:0];
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        // Only the UART's done moves us on; requests and words are ignored here.
        if (i_tx_done) begin
          if (byte_cnt == CNT_W'(WORD_BYTES - 1)) begin
            word_done_nxt = 1'b1;
            done_id_nxt   = last_grant;
            busy_nxt      = 1'b0;
            state_nxt     = ST_IDLE;
          end else begin
            shift_nxt    = shift_q >> 8;
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
            state_nxt    = ST_SEND;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      shift_q     <= '0;
      byte_cnt    <= '0;
      // Pointer at the last index so requester 0 is scanned first after reset.
      last_grant  <= ID_W'(NUM_REQ - 1);
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_word_done <= 1'b0;
      o_done_id   <= '0;
    end else begin
      state       <= state_nxt;
      shift_q     <= shift_nxt;
      byte_cnt    <= byte_cnt_nxt;
      last_grant  <= last_grant_nxt;
      o_grant     <= grant_nxt;
      o_busy      <= busy_nxt;
      o_tx_start  <= tx_start_nxt;
      o_tx_data   <= tx_data_nxt;
      o_word_done <= word_done_nxt;
      o_done_id   <= done_id_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: behavioural UART plus a round-robin/byte-order reference model.
// Directed scenarios (single word, round-robin, latch stability, mid-word reset, stray done,
// back-to-back) followed by randomized requests, words and UART latencies.
module tb_uart_tx_scheduler;
  localparam int NR  = 3;
  localparam int WB  = 4;
  localparam int DW  = 8 * WB;
  localparam int IDW = $clog2(NR);

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [NR-1:0]     i_req;
  logic [NR*DW-1:0]  i_word;
  logic [NR-1:0]     o_grant;
  logic              o_busy;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              i_tx_done;
  logic              o_word_done;
  logic [IDW-1:0]    o_done_id;

  logic model_done = 1'b0;
  logic stray_done = 1'b0;
  assign i_tx_done = model_done | stray_done;

  uart_tx_scheduler #(.NUM_REQ(NR), .WORD_BYTES(WB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_word(i_word),
    .o_grant(o_grant), .o_busy(o_busy), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(i_tx_done), .o_word_done(o_word_done), .o_done_id(o_done_id)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Behavioural UART: done pulse uart_n cycles after a start; flags a start while busy.
  int         uart_n    = 3;
  int         uart_left = 0;
  int         dbl       = 0;
  int         unstable  = 0;
  logic [7:0] cur_byte  = 8'h00;
  logic [7:0] byte_q[$];
  int         start_cyc_q[$];
  int         done_cyc_q[$];
  logic [NR-1:0]  grant_q[$];
  logic [IDW-1:0] wd_id_q[$];
  int             wd_cyc_q[$];

  always @(negedge i_clk) begin
    model_done = 1'b0;
    if (i_reset) begin
      uart_left = 0;
    end else begin
      if (uart_left > 0) begin
        uart_left--;
        if (uart_left == 0) begin
          model_done = 1'b1;
          done_cyc_q.push_back(cyc);
          if (o_tx_data !== cur_byte) unstable++;
        end
      end
      if (o_tx_start) begin
        if (uart_left > 0) dbl++;
        byte_q.push_back(o_tx_data);
        cur_byte = o_tx_data;
        start_cyc_q.push_back(cyc);
        uart_left = uart_n;
      end
    end
  end

  always @(negedge i_clk) begin
    if (o_grant != '0) grant_q.push_back(o_grant);
    if (o_word_done) begin
      wd_id_q.push_back(o_done_id);
      wd_cyc_q.push_back(cyc);
    end
  end

  // Reference arbitration pointer: index of the most recent grant.
  int ref_last = NR - 1;

  function automatic int rr_pick(input int last, input logic [NR-1:0] req);
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (last + i) % NR;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    byte_q.delete(); start_cyc_q.delete(); done_cyc_q.delete();
    grant_q.delete(); wd_id_q.delete(); wd_cyc_q.delete();
    dbl = 0; unstable = 0;
  endtask

  task automatic set_word(input int k, input logic [DW-1:0] w);
    i_word[k*DW +: DW] = w;
  endtask

  task automatic rand_words();
    for (int j = 0; j < NR*DW; j++) i_word[j] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_req = '0; stray_done = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("reset grant", o_grant, 0);
    chk("reset busy", o_busy, 0);
    chk("reset tx_start", o_tx_start, 0);
    chk("reset tx_data", o_tx_data, 0);
    chk("reset word_done", o_word_done, 0);
    chk("reset done_id", o_done_id, 0);
    i_reset = 1'b0;
    ref_last = NR - 1;
  endtask

  // One complete word: request, check grant, optionally disturb, then check the byte stream.
  // clob: 0 leave words, 1 zero all words after grant, 2 randomize all words after grant.
  task automatic serve(input string tag, input logic [NR-1:0] req, input logic [NR-1:0] after,
                       input int clob, input bit stray);
    int id, c0, gc, gaps_bad;
    logic [DW-1:0] w;
    bit ok;
    id = rr_pick(ref_last, req);
    w  = DW'(i_word >> (id * DW));
    clear_logs();
    c0 = cyc;
    i_req = req;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge i_clk);
      if (o_grant != '0) ok = 1;
    end
    chk({tag, " grant seen"}, ok, 1);
    gc = cyc;
    chk({tag, " grant latency"}, gc - c0, 1);
    chk({tag, " grant onehot"}, o_grant, NR'(1) << id);
    chk({tag, " busy at grant"}, o_busy, 1);
    i_req = after;
    if (clob == 1) i_word = '0;
    else if (clob == 2) rand_words();
    if (stray) begin
      stray_done = 1'b1;
      @(negedge i_clk);
      stray_done = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge i_clk);
      if (o_word_done) ok = 1;
    end
    #1;
    chk({tag, " word_done seen"}, ok, 1);
    chk({tag, " busy after word"}, o_busy, 0);
    chk({tag, " done_id"}, o_done_id, id);
    chk({tag, " one word_done"}, wd_id_q.size(), 1);
    chk({tag, " one grant"}, grant_q.size(), 1);
    chk({tag, " start count"}, byte_q.size(), WB);
    for (int b = 0; b < WB; b++)
      chk($sformatf("%s byte%0d", tag, b), (b < byte_q.size()) ? byte_q[b] : 8'hxx, 8'((w >> (8 * b)) & 'hFF));
    chk({tag, " first start"}, (start_cyc_q.size() > 0) ? start_cyc_q[0] - gc : -1, 1);
    gaps_bad = 0;
    for (int b = 1; b < WB; b++) begin
      if (b < start_cyc_q.size() && b - 1 < done_cyc_q.size()) begin
        if (start_cyc_q[b] - done_cyc_q[b-1] != 2) gaps_bad++;
      end else begin
        gaps_bad++;
      end
    end
    chk({tag, " done->start gaps"}, gaps_bad, 0);
    chk({tag, " word_done after last done"},
        (wd_cyc_q.size() > 0 && done_cyc_q.size() >= WB) ? wd_cyc_q[0] - done_cyc_q[WB-1] : -1, 1);
    chk({tag, " double start"}, dbl, 0);
    chk({tag, " data stable"}, unstable, 0);
    ref_last = id;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    i_reset = 1'b1; i_req = '0; i_word = '0;
    do_reset();

    // Single word
    set_word(0, DW'(64'hDEADBEEF));
    serve("single", NR'(1), '0, 0, 0);

    // Round-robin with all requests held
    do_reset();
    set_word(0, DW'(64'h11111111));
    set_word(1, DW'(64'h22222222));
    set_word(2, DW'(64'h33333333));
    serve("rr0", '1, '1, 0, 0);
    serve("rr1", '1, '1, 0, 0);
    serve("rr2", '1, '1, 0, 0);
    serve("rr3", '1, '0, 0, 0);
    chk("rr wraps to 0", ref_last, 0);

    // Word latched at grant; source cleared right after
    set_word(0, DW'(64'hCAFEF00D));
    serve("latch", NR'(1), '0, 1, 0);

    // Reset after the second byte's done
    set_word(1, DW'(64'h89ABCDEF));
    clear_logs();
    i_req = NR'(2);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge i_clk);
      if (o_grant != '0) ok = 1;
    end
    chk("rst grant seen", ok, 1);
    i_req = '0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge i_clk);
      #1;
      if (done_cyc_q.size() >= 2) ok = 1;
    end
    chk("rst 2nd done seen", ok, 1);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("midrst grant", o_grant, 0);
    chk("midrst busy", o_busy, 0);
    chk("midrst tx_start", o_tx_start, 0);
    chk("midrst tx_data", o_tx_data, 0);
    chk("midrst word_done", o_word_done, 0);
    chk("midrst done_id", o_done_id, 0);
    i_reset = 1'b0;
    repeat (6) @(negedge i_clk);
    chk("midrst no word_done", wd_id_q.size(), 0);
    chk("midrst starts abandoned", byte_q.size(), 2);
    ref_last = NR - 1;
    set_word(1, DW'(64'h5A6B7C8D));
    serve("post-rst", NR'(6), '0, 0, 0);

    // Stray done in IDLE, then in SEND
    clear_logs();
    @(negedge i_clk);
    stray_done = 1'b1;
    @(negedge i_clk);
    stray_done = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("stray idle starts", start_cyc_q.size(), 0);
    chk("stray idle grants", grant_q.size(), 0);
    chk("stray idle busy", o_busy, 0);
    set_word(2, DW'(64'h0F1E2D3C));
    serve("stray send", NR'(4), '0, 0, 1);

    // Back-to-back: requester 1 raises its request while requester 0 is sending
    set_word(0, DW'(64'hA1A2A3A4));
    set_word(1, DW'(64'hB1B2B3B4));
    serve("b2b first", NR'(1), NR'(2), 0, 0);
    serve("b2b second", NR'(2), '0, 0, 0);

    // Randomized traffic
    for (int it = 0; it < 24; it++) begin
      uart_n = $urandom_range(1, 6);
      rand_words();
      serve($sformatf("rnd%0d", it), NR'($urandom_range(1, (1 << NR) - 1)),
            NR'($urandom_range(0, (1 << NR) - 1)), 2 * $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
    i_req = '0;
    repeat (4) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
